// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals around memory_arbiter.
// The arbiter uses the slave view; requesters and memory together use the master view.
interface memory_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_done, if_rdata, if_err, d_done, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_done, if_rdata, if_err, d_done, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a data port,
// with a per-transaction timeout. Every output comes straight from a flop.
module memory_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = data port granted last
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_done_q, d_done_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_done_d     = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the memory.
        if (bus.d_req && (!bus.if_req || !last_grant_q)) begin
          state_d      = BUSY_D;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d      = BUSY_I;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Memory never answered: release it and report the abort on the owning port.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_done_d  = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_done_q     <= d_done_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, width of all address buses.
REQ-002 Parameter DATA_W, default 64, width of all data buses.
REQ-003 Parameter TIMEOUT, default 16, max cycles mem_req may stay high without mem_ready; legal range 2..255.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 if_req  input  1  fetch port request; held high with if_addr stable until if_done.
REQ-007 if_addr  input  ADDR_W  fetch read address.
REQ-008 if_done  output  1  one-cycle completion pulse, fetch port.
REQ-009 if_rdata  output  DATA_W  fetch read data; valid while if_done=1.
REQ-010 if_err  output  1  fetch timeout flag; valid while if_done=1.
REQ-011 d_req  input  1  data port request; held high with d_we/d_addr/d_wdata stable until d_done.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_done / d_rdata / d_err  output  1 / DATA_W / 1  data-port equivalents of if_done / if_rdata / if_err.
REQ-016 mem_req  output  1  request to shared single-port memory.
REQ-017 mem_we, mem_addr, mem_wdata  output  1, ADDR_W, DATA_W  registered command to memory.
REQ-018 mem_ready  input  1  memory completion, single cycle; qualifies mem_rdata.
REQ-019 mem_rdata  input  DATA_W  memory read data.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states: IDLE, BUSY_I (fetch granted), BUSY_D (data granted); all outputs registered.
REQ-022 IDLE, exactly one req high -> grant that port at next edge.
REQ-023 IDLE, both reqs high -> grant port not granted last (round-robin); last_grant is 1 bit, updated on every grant.
REQ-024 On grant edge: latch mem_addr/mem_we/mem_wdata from granted port (mem_we=0 for fetch), set mem_req=1, clear timeout counter.
REQ-025 mem_req stays high, command fields stable, until completion or timeout; no new grant while busy.
REQ-026 Completion: edge with mem_req=1 and mem_ready=1 -> mem_req=0, granted port done=1 for exactly the next cycle, rdata=mem_rdata for loads/fetch, rdata=0 for stores, err=0, state IDLE.
REQ-027 Timeout: counter increments each busy edge with mem_ready=0; edge where counter==TIMEOUT-1 and mem_ready=0 -> abort: mem_req=0, done=1, err=1, rdata=0, state IDLE; mem_req therefore high exactly TIMEOUT cycles.
REQ-028 mem_ready=1 on the timeout edge -> normal completion, no error.
REQ-029 mem_ready while mem_req=0 ignored.
REQ-030 Req high during its own done cycle is a new request, arbitrated normally (back-to-back allowed).
REQ-031 Non-granted port's done/err stay 0; rdata of a port holds last value except cleared per REQ-026/027.
REQ-032 Minimum latency: req sampled at edge k -> mem_req high cycle k+1 -> done earliest cycle k+2 (mem_ready in cycle k+1).

Reset
REQ-033 reset=0 asynchronously forces IDLE, all outputs 0, counter 0, last_grant=fetch (data wins first tie).
REQ-034 Reset mid-transaction abandons it with no done pulse; mem_req falls immediately, without waiting for a clock.
REQ-035 First grant possible at first rising edge after reset deasserts.

Verification
REQ-036 Reset: reset=0 with reqs high -> all outputs 0, busy=0; release -> grant at next edge.
REQ-037 Fetch: if_addr=0x100, mem_ready 2nd mem_req cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, mem_req high 2 cycles, if_done 1 cycle, if_rdata=0xDEADBEEF, if_err=0.
REQ-038 Tie after reset: if_req and d_req both high -> data served first, then fetch; two further ties alternate D,I.
REQ-039 Store: d_we=1, d_addr=0x40, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234; d_done with d_rdata=0, d_err=0.
REQ-040 Timeout TIMEOUT=4, mem_ready never -> mem_req high exactly 4 cycles, then d_done=1, d_err=1, d_rdata=0; ready on 4th cycle -> d_err=0.
REQ-041 Reset mid-BUSY_I -> mem_req=0 asynchronously, no if_done; next request granted normally.
